// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the 8N1 byte receiver:
// FSM encoding, oversample ratio, vote sample points.
package uart_rx_byte_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int VOTE_A     = 7;
    localparam int VOTE_B     = 8;
    localparam int VOTE_C     = 9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks,
// re-phased to the start edge through restart.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver, 16x oversampled with 3-sample majority vote.
// Drives the servo position register through rx_data / rx_valid.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int         CLK_HZ     = 100_000_000,
    parameter int         BAUD       = 115_200,
    parameter logic [7:0] RESET_DATA = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

    state_t     state, state_n;
    logic       rx_m, rx_s;
    logic       tick, restart;
    logic [3:0] sc, sc_n;
    logic [2:0] bc, bc_n;
    logic [7:0] shift, shift_n;
    logic       s7, s7_n, s8, s8_n;
    logic [7:0] data_n;
    logic       valid_n, ferr_n;
    logic       vote, decide, in_frame;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign busy     = (state != ST_IDLE);
    assign in_frame = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign decide   = tick && (sc == 4'(VOTE_C));
    assign vote     = maj3(s7, s8, rx_s);

    always_comb begin
        state_n = state;
        sc_n    = sc;
        bc_n    = bc;
        shift_n = shift;
        s7_n    = s7;
        s8_n    = s8;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        restart = 1'b0;

        if (tick && in_frame) begin
            sc_n = sc + 4'd1;
            if (sc == 4'(VOTE_A)) s7_n = rx_s;
            if (sc == 4'(VOTE_B)) s8_n = rx_s;
        end

        unique case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    sc_n    = 4'd0;
                    restart = 1'b1;
                end
            end
            ST_START: begin
                if (decide) begin
                    if (!vote) begin
                        state_n = ST_DATA;
                        bc_n    = 3'd0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_n = {vote, shift[7:1]};
                    bc_n    = bc + 3'd1;
                    if (bc == 3'd7) state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (vote) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        sc_n    = 4'd0;
                        state_n = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // sc counts consecutive high ticks; any low sample restarts it
                if (tick) begin
                    if (!rx_s) begin
                        sc_n = 4'd0;
                    end else if (sc == 4'd15) begin
                        sc_n    = 4'd0;
                        state_n = ST_IDLE;
                    end else begin
                        sc_n = sc + 4'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= ST_IDLE;
            sc        <= 4'd0;
            bc        <= 3'd0;
            shift     <= 8'd0;
            s7        <= 1'b0;
            s8        <= 1'b0;
            rx_data   <= RESET_DATA;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            state     <= state_n;
            sc        <= sc_n;
            bc        <= bc_n;
            shift     <= shift_n;
            s7        <= s7_n;
            s8        <= s8_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

endmodule
